// File: rtl/regfile_wb_arb.sv
// Write-back arbiter for a 16-entry register file: two requesters share one write port
// under a 1-bit round-robin pointer, with a 15-cycle clear sweep after reset or on request.
module regfile_wb_arb #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic [AW-1:0]     rf_wp,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_we,
  output logic              rf_rst
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ptr_q, ptr_d;  // 0 = A, 1 = B
  logic [AW-1:0]       rf_wp_q, rf_wp_d;
  logic [DATA_W-1:0]   rf_din_q, rf_din_d;
  logic                rf_we_q, rf_we_d;
  logic                rf_rst_q, rf_rst_d;

  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    rf_wp_d  = rf_wp_q;
    rf_din_d = rf_din_q;
    rf_we_d  = 1'b0;
    rf_rst_d = 1'b0;
    case (state_q)
      INIT: begin
        // clr_req is ignored here so an in-flight sweep never restarts
        rf_rst_d = 1'b1;
        rf_wp_d  = AW'(cnt_q);
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = RUN;
      end
      default: begin
        if (clr_req) begin
          cnt_d   = 4'd1;
          state_d = INIT;
        end else begin
          a_ready = a_valid && (!b_valid || !ptr_q);
          b_ready = b_valid && (!a_valid ||  ptr_q);
          if (a_ready) begin
            rf_wp_d  = a_addr;
            rf_din_d = a_data;
            rf_we_d  = (a_addr != '0);
            ptr_d    = 1'b1;
          end else if (b_ready) begin
            rf_wp_d  = b_addr;
            rf_din_d = b_data;
            rf_we_d  = (b_addr != '0);
            ptr_d    = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      cnt_q    <= 4'd1;
      ptr_q    <= 1'b0;
      rf_wp_q  <= '0;
      rf_din_q <= '0;
      rf_we_q  <= 1'b0;
      rf_rst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rf_wp_q  <= rf_wp_d;
      rf_din_q <= rf_din_d;
      rf_we_q  <= rf_we_d;
      rf_rst_q <= rf_rst_d;
    end
  end

  assign busy   = (state_q == INIT);
  assign rf_wp  = rf_wp_q;
  assign rf_din = rf_din_q;
  assign rf_we  = rf_we_q;
  assign rf_rst = rf_rst_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: clear sweep, arbitration, r0 drop, clr_req and mid-sweep reset.
module tb_regfile_wb_arb;
  localparam int DATA_W = 32;
  localparam int AW     = 4;

  logic              clk, rst_n;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0]     a_addr, b_addr, rf_wp;
  logic [DATA_W-1:0] a_data, b_data, rf_din;
  logic              clr_req, busy, rf_we, rf_rst;

  int n_chk, n_err;

  regfile_wb_arb #(.DATA_W(DATA_W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .clr_req(clr_req), .busy(busy),
    .rf_wp(rf_wp), .rf_din(rf_din), .rf_we(rf_we), .rf_rst(rf_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; sample/drive 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit pulse_clr);
    for (int i = 1; i <= 15; i++) begin
      chk("ready_a_init", a_ready, 0);
      chk("ready_b_init", b_ready, 0);
      tick();
      clr_req = (pulse_clr && i == 4);
      chk("sweep_rst", rf_rst, 1);
      chk("sweep_we", rf_we, 0);
      chk("sweep_wp", rf_wp, i);
      chk("sweep_busy", busy, (i < 15));
    end
    clr_req = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; clr_req = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #3;
    chk("rst_we", rf_we, 0);
    chk("rst_rst", rf_rst, 0);
    chk("rst_wp", rf_wp, 0);
    chk("rst_din", rf_din, 0);
    chk("rst_busy", busy, 1);
    tick(); tick();
    rst_n = 1'b1;

    // reset sweep with A already waiting; A must not win until RUN
    a_valid = 1'b1; a_addr = 4'd2; a_data = 32'h0000_0022;
    sweep(1'b0);
    chk("first_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("first_we", rf_we, 1);
    chk("first_rst", rf_rst, 0);
    chk("first_wp", rf_wp, 2);
    chk("first_din", rf_din, 32'h22);

    // only B valid, pointer at B
    b_valid = 1'b1; b_addr = 4'd7; b_data = 32'h1234_5678;
    #1;
    chk("bonly_b_ready", b_ready, 1);
    chk("bonly_a_ready", a_ready, 0);
    tick();
    b_valid = 1'b0;
    chk("bonly_we", rf_we, 1);
    chk("bonly_wp", rf_wp, 7);
    chk("bonly_din", rf_din, 32'h1234_5678);

    // both valid: pointer now A, grants alternate A,B,A,B
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'hAAAA_0001;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 32'hBBBB_0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_a_ready", a_ready, (k % 2 == 0));
      chk("alt_b_ready", b_ready, (k % 2 == 1));
      tick();
      chk("alt_we", rf_we, 1);
      chk("alt_wp", rf_wp, (k % 2 == 0) ? 3 : 5);
      chk("alt_din", rf_din, (k % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // idle: we drops, wp/din hold
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_rst", rf_rst, 0);
    chk("idle_wp", rf_wp, 5);
    chk("idle_din", rf_din, 32'hBBBB_0002);

    // write to r0 accepted but suppressed
    a_valid = 1'b1; a_addr = 4'd0; a_data = 32'hFFFF_FFFF;
    #1;
    chk("r0_a_ready", a_ready, 1);
    tick();
    chk("r0_we", rf_we, 0);
    // pointer flipped to B
    b_valid = 1'b1; a_addr = 4'd3; a_data = 32'hAAAA_0001;
    #1;
    chk("ptr_b_ready", b_ready, 1);
    chk("ptr_a_ready", a_ready, 0);

    // clr_req with both valid blocks both; second clr_req mid-sweep ignored
    clr_req = 1'b1;
    #1;
    chk("clr_a_ready", a_ready, 0);
    chk("clr_b_ready", b_ready, 0);
    tick();
    clr_req = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_we", rf_we, 0);
    chk("clr_rst", rf_rst, 0);
    sweep(1'b1);
    chk("post_clr_b_ready", b_ready, 1);
    chk("post_clr_a_ready", a_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;

    // reset mid-sweep at cnt=8
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk("pre_abort_wp", rf_wp, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_wp", rf_wp, 0);
    chk("abort_rst", rf_rst, 0);
    chk("abort_we", rf_we, 0);
    chk("abort_din", rf_din, 0);
    chk("abort_busy", busy, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_rst", rf_rst, 1);
    chk("restart_wp", rf_wp, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter DATA_W, default 32, width of write-back data.
REQ-002 Parameter AW, default 4, register address width (16 registers; r0 hardwired to zero).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a_valid  input  1  requester A (ALU write-back) has a write pending.
REQ-006 a_addr  input  AW  requester A destination register.
REQ-007 a_data  input  DATA_W  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle; combinational.
REQ-009 b_valid  input  1  requester B (load unit) has a write pending.
REQ-010 b_addr  input  AW  requester B destination register.
REQ-011 b_data  input  DATA_W  requester B write data.
REQ-012 b_ready  output  1  requester B write accepted this cycle; combinational.
REQ-013 clr_req  input  1  single-cycle pulse requesting a clear of every register.
REQ-014 busy  output  1  clear sequence in progress; registered.
REQ-015 rf_wp  output  AW  register file write-port address; registered.
REQ-016 rf_din  output  DATA_W  register file write data; registered.
REQ-017 rf_we  output  1  register file write enable; registered.
REQ-018 rf_rst  output  1  register file per-address clear; registered.

Function
REQ-019 The FSM SHALL have two states: INIT (clearing registers) and RUN (arbitrating writes); busy SHALL be 1 exactly when in INIT.
REQ-020 INIT SHALL use a 4-bit counter cnt running 1..15; each INIT edge SHALL register rf_rst=1, rf_we=0, rf_wp=cnt, and increment cnt.
REQ-021 INIT SHALL transition to RUN on the edge that issues rf_wp=15, so a clear lasts exactly 15 cycles.
REQ-022 a_ready and b_ready SHALL both be 0 in INIT.
REQ-023 In RUN, a handshake SHALL occur when valid && ready; at most one of a_ready and b_ready SHALL be 1 per cycle.
REQ-024 If exactly one requester is valid, it SHALL be granted.
REQ-025 If both requesters are valid, the one selected by a 1-bit round-robin pointer SHALL be granted.
REQ-026 The pointer SHALL point to the other requester after every grant; with no grant, it SHALL hold.
REQ-027 A granted write SHALL appear on rf_wp, rf_din and rf_we=1 on the next edge (1-cycle latency), with rf_rst=0.
REQ-028 A granted write to address 0 SHALL be accepted (ready=1, pointer updates) but SHALL produce rf_we=0.
REQ-029 Every cycle without a grant, the block SHALL register rf_we=0 and rf_rst=0 and SHALL hold rf_wp and rf_din.
REQ-030 rf_we and rf_rst SHALL never both be 1.
REQ-031 A clr_req sampled in RUN SHALL force a_ready=b_ready=0 that cycle, reset cnt to 1, and enter INIT on the next edge.
REQ-032 clr_req sampled in INIT SHALL be ignored; the sweep SHALL not restart.
REQ-033 Requesters SHALL hold valid, addr and data stable until handshake; the block SHALL not buffer more than the one registered write.

Reset
REQ-034 While rst_n=0: rf_we=0, rf_rst=0, rf_wp=0, rf_din=0, state=INIT, cnt=1, busy=1, pointer=A.
REQ-035 rst_n assertion mid-INIT or mid-RUN SHALL abort immediately; any unissued write is lost, and the full 15-cycle clear SHALL restart after release.
REQ-036 The first edge after rst_n release SHALL register rf_rst=1 and rf_wp=1.

Verification
REQ-037 Reset release -> 15 consecutive cycles rf_rst=1, rf_wp=1..15, then busy=0; the earliest write handshake occurs on the cycle after the rf_wp=15 edge.
REQ-038 Both requesters are valid for 4 cycles (A addr 3 data 0xAAAA0001, B addr 5 data 0xBBBB0002), with each requester presenting a new write after every handshake -> grants alternate A,B,A,B; rf_wp alternates 3,5 with matching data one cycle later.
REQ-039 Only B is valid with pointer=B and addr 7 data 0x12345678 -> b_ready=1, next edge rf_we=1, rf_wp=7, rf_din=0x12345678.
REQ-040 A is valid with addr 0 data 0xFFFFFFFF -> a_ready=1, next edge rf_we=0, pointer flips to B.
REQ-041 clr_req is pulsed while both requesters are valid -> both ready=0 that cycle, then a 15-cycle sweep; a second clr_req during the sweep changes nothing.
REQ-042 rst_n is asserted mid-sweep at cnt=8 -> outputs are zero immediately; after release the sweep restarts at rf_wp=1.
